logic_unit_serial: RTL and testbench
====================================

LOGIC_UNIT_SERIAL -- requirements
Module: logic_unit_serial

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter W, default 2, giving the slice width processed per cycle; N SHALL be an integer multiple of W, and W SHALL be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled in IDLE only.
REQ-006 The block SHALL have port op, input, 3 bits: operation select, captured with start.
REQ-007 The block SHALL have port a, input, N bits: operand A, captured with start.
REQ-008 The block SHALL have port b, input, N bits: operand B, captured with start.
REQ-009 The block SHALL have port busy, output, 1 bit: high while slices are being processed.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse, high when result and flags are valid.
REQ-011 The block SHALL have port result, output, N bits: last completed result, held until the next completion.
REQ-012 The block SHALL have port zero, output, 1 bit: high when result is all zeros.
REQ-013 The block SHALL have port parity, output, 1 bit: XOR reduction of result.

Function
REQ-014 The op encoding SHALL be:
- 000 AND
- 001 OR
- 010 XOR
- 011 NOT a (b ignored)
- 100 NAND
- 101 NOR
- 110 XNOR
- 111 pass b
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 In IDLE with start=1, the block SHALL capture a, b and op into internal registers, clear the slice counter to 0, and enter RUN.
REQ-017 In RUN, each cycle SHALL compute slice k, bits [k*W +: W], from the captured operands and write it into a working register; slices SHALL be processed LSB first.
REQ-018 The slice counter SHALL increment from 0 to N/W-1; after slice N/W-1 the FSM SHALL enter DONE, with no counter wrap observable outside.
REQ-019 On the IDLE->RUN edge's successor, i.e. when entering DONE, result, zero and parity SHALL be loaded from the completed working register.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-021 Latency: start sampled at edge t SHALL give done=1 during the cycle after edge t+N/W+1, i.e. N/W+1 cycles from start acceptance to done.
REQ-022 busy SHALL be 1 exactly while in RUN; done and busy SHALL never both be 1.
REQ-023 start SHALL be ignored in RUN and DONE; changes to a, b or op after capture SHALL NOT affect the operation in flight.
REQ-024 When start is held high, a new operation SHALL be accepted on the first IDLE cycle following DONE.
REQ-025 result, zero and parity SHALL change only on entry to DONE or on reset; partial results SHALL never be visible on result.
REQ-026 For W=N the block SHALL process the operand in a single RUN cycle, giving a latency of 2.

Reset
REQ-027 rst=1 at a rising edge SHALL force state to IDLE, clear the slice counter, and set busy=0, done=0, result=0, zero=1 and parity=0.
REQ-028 rst SHALL take priority over start and over any state transition.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no result update.

Verification
REQ-030 N=8, W=2, op=010, a=A5h, b=0Fh, start one cycle -> busy high 4 cycles, then done pulse 5 cycles after acceptance, result=AAh, zero=0, parity=0.
REQ-031 N=8, W=2, op=000, a=F0h, b=0Fh -> result=00h, zero=1, parity=0; then op=011, a=00h -> result=FFh, zero=0, parity=0.
REQ-032 Start pulsed again and a changed to FFh during RUN of an op=001, a=01h, b=02h operation -> exactly one done pulse, result=03h, parity=0.
REQ-033 rst asserted in the 2nd RUN cycle of op=111, b=5Ah -> no done pulse, result=00h, zero=1, busy=0 on the next cycle.
REQ-034 start held high across three back-to-back op=100, a=FFh, b=0Fh operations -> done pulses spaced N/W+2=6 cycles apart, each with result=F0h, parity=0.
REQ-035 N=8, W=8, op=101, a=00h, b=00h -> done 2 cycles after acceptance, result=FFh, zero=0, parity=0.

Source files
------------

// File: rtl/logic_unit_serial.sv
// rtl/logic_unit_serial.sv - bit-sliced bitwise logic unit, W bits per cycle, LSB slice first
// Operands are captured on start; result and flags update only when the last slice lands.
module logic_unit_serial #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         parity
);

  localparam int S  = N / W;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_work;

  logic [W-1:0]  w_sa;
  logic [W-1:0]  w_sb;
  logic [W-1:0]  w_slice;
  logic [N-1:0]  w_work_next;
  logic          w_last;

  always_comb begin
    w_sa    = r_a[int'(r_cnt) * W +: W];
    w_sb    = r_b[int'(r_cnt) * W +: W];
    w_slice = '0;
    case (r_op)
      3'b000:  w_slice = w_sa & w_sb;
      3'b001:  w_slice = w_sa | w_sb;
      3'b010:  w_slice = w_sa ^ w_sb;
      3'b011:  w_slice = ~w_sa;
      3'b100:  w_slice = ~(w_sa & w_sb);
      3'b101:  w_slice = ~(w_sa | w_sb);
      3'b110:  w_slice = ~(w_sa ^ w_sb);
      default: w_slice = w_sb;
    endcase
    // Result/flags must see the slice being written on this same edge.
    w_work_next = r_work;
    w_work_next[int'(r_cnt) * W +: W] = w_slice;
    w_last = (r_cnt == CW'(S - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      parity  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_state <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          r_work <= w_work_next;
          if (w_last) begin
            r_state <= DONE;
            busy    <= 1'b0;
            result  <= w_work_next;
            zero    <= ~|w_work_next;
            parity  <= ^w_work_next;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_serial.sv
// tb/tb_logic_unit_serial.sv - directed bench for logic_unit_serial (N=8 with W=2 and W=8)
module tb_logic_unit_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       busy0, done0, zero0, parity0;
  logic       busy1, done1, zero1, parity1;
  logic [7:0] result0, result1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_unit_serial #(.N(8), .W(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(result0), .zero(zero0), .parity(parity0)
  );

  logic_unit_serial #(.N(8), .W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1), .zero(zero1), .parity(parity1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // j counts negedges after the acceptance edge; j=0 is the cycle right after it.
  task automatic run_op(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input bit disturb, output int lat, output int busy_n,
                        output int done_n, output int both, output int partial,
                        output logic [7:0] res, output logic z, output logic p);
    logic [7:0] prev;
    lat = -1; busy_n = 0; done_n = 0; both = 0; partial = 0;
    res = 'x; z = 'x; p = 'x;
    @(negedge clk);
    op = o; a = xa; b = xb; start0 = 1'b1;
    @(posedge clk);
    prev = result0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (busy0) busy_n++;
      if (busy0 && done0) both++;
      if (busy0 && result0 !== prev) partial++;
      if (done0) begin
        done_n++;
        if (lat < 0) begin
          lat = j; res = result0; z = zero0; p = parity0;
        end
      end
      start0 = 1'b0;
      if (disturb && j == 1) begin
        start0 = 1'b1; a = 8'hFF; op = 3'b111;
      end
    end
  endtask

  int lat, busy_n, done_n, both, partial;
  logic [7:0] res;
  logic z, p;
  int dpos[$];

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   busy0,   0);
    chk("rst_done",   done0,   0);
    chk("rst_result", result0, 8'h00);
    chk("rst_zero",   zero0,   1);
    chk("rst_parity", parity0, 0);
    chk("rst_zero_w8", zero1,  1);
    rst = 1'b0;

    run_op(3'b010, 8'hA5, 8'h0F, 0, lat, busy_n, done_n, both, partial, res, z, p);
    chk("xor_latency", lat, 5);
    chk("xor_busy_cycles", busy_n, 4);
    chk("xor_done_count", done_n, 1);
    chk("xor_busy_done_overlap", both, 0);
    chk("xor_partial_visible", partial, 0);
    chk("xor_result", res, 8'hAA);
    chk("xor_zero", z, 0);
    chk("xor_parity", p, 0);

    run_op(3'b000, 8'hF0, 8'h0F, 0, lat, busy_n, done_n, both, partial, res, z, p);
    chk("and_result", res, 8'h00);
    chk("and_zero", z, 1);
    chk("and_parity", p, 0);

    run_op(3'b011, 8'h00, 8'h3C, 0, lat, busy_n, done_n, both, partial, res, z, p);
    chk("not_result", res, 8'hFF);
    chk("not_zero", z, 0);
    chk("not_parity", p, 0);

    run_op(3'b001, 8'h01, 8'h02, 1, lat, busy_n, done_n, both, partial, res, z, p);
    chk("or_disturb_done_count", done_n, 1);
    chk("or_disturb_result", res, 8'h03);
    chk("or_disturb_parity", p, 0);

    // Reset in the second RUN cycle: abort with no done and cleared outputs.
    @(negedge clk);
    op = 3'b111; a = 8'h00; b = 8'h5A; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_result", result0, 8'h00);
    chk("abort_zero", zero0, 1);
    rst = 1'b0;
    done_n = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done0) done_n++;
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_result_hold", result0, 8'h00);

    // start held high: three back-to-back NAND operations.
    @(negedge clk);
    op = 3'b100; a = 8'hFF; b = 8'h0F; start0 = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (done0) begin
        dpos.push_back(j);
        chk("b2b_result", result0, 8'hF0);
        chk("b2b_parity", parity0, 0);
      end
      if (j == 12) start0 = 1'b0;
    end
    chk("b2b_done_count", dpos.size(), 3);
    if (dpos.size() == 3) begin
      chk("b2b_first_done", dpos[0], 5);
      chk("b2b_spacing1", dpos[1] - dpos[0], 6);
      chk("b2b_spacing2", dpos[2] - dpos[1], 6);
    end

    // Single-slice instance.
    @(negedge clk);
    op = 3'b101; a = 8'h00; b = 8'h00; start1 = 1'b1;
    @(posedge clk);
    lat = -1; busy_n = 0; done_n = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (busy1) busy_n++;
      if (done1) begin
        done_n++;
        if (lat < 0) begin
          lat = j; res = result1; z = zero1; p = parity1;
        end
      end
    end
    chk("w8_latency", lat, 2);
    chk("w8_busy_cycles", busy_n, 1);
    chk("w8_done_count", done_n, 1);
    chk("w8_result", res, 8'hFF);
    chk("w8_zero", z, 0);
    chk("w8_parity", p, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
